// File: rtl/ntt_mdc_commutator_rt_pkg.sv
// -----------------------------------------------------------------------------
// ntt_mdc_commutator_rt_pkg
// Shared definitions for the runtime-configurable MDC commutator:
//   - controller state encoding (IDLE, FILL, RUN, DRAIN)
//   - default word width and channel-packing helper
//   - depth threshold between distributed-RAM and block-RAM delay lines
// -----------------------------------------------------------------------------
package ntt_mdc_commutator_rt_pkg;

  // Default NTT coefficient word width.
  localparam int LOGQ_DEF = 64;

  // Widest channel count the packing helper handles.
  localparam int CH_MAX = 8;

  // Delay lines up to 2^DIST_RAM_MAX_LOGD entries use an asynchronous-read
  // (LUT) memory; deeper ones switch to a registered-read (block) memory.
  localparam int DIST_RAM_MAX_LOGD = 7;

  // Controller states, kept as plain constants for legacy tool flows.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FILL  = 2'd1;
  localparam state_t ST_RUN   = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

  // Extract the LOGQ_DEF-bit word of channel c from a packed bus
  // (channel c lives at bits [c*LOGQ_DEF +: LOGQ_DEF]).
  function automatic logic [LOGQ_DEF-1:0] ch_word(
    input logic [CH_MAX*LOGQ_DEF-1:0] v,
    input int unsigned                c
  );
    return v[c*LOGQ_DEF +: LOGQ_DEF];
  endfunction

endpackage

// File: rtl/ntt_mdc_commutator_rt_if.sv
// -----------------------------------------------------------------------------
// ntt_mdc_commutator_rt_if
// Bus bundle for the MDC commutator.
//   Control : cfg_load, cfg_log_d, flush
//   Input   : in_valid, in_data0, in_data1 (CH words of LOGQ bits each)
//   Output  : out_valid, out_data0, out_data1, busy, err
// Modports: master drives control/input and observes outputs (producer side),
// slave is the commutator itself.
// -----------------------------------------------------------------------------
interface ntt_mdc_commutator_rt_if #(
  parameter int LOGQ  = 64,
  parameter int CH    = 1,
  parameter int LOGDW = 3
);

  logic                 cfg_load;
  logic [LOGDW-1:0]     cfg_log_d;
  logic                 in_valid;
  logic [CH*LOGQ-1:0]   in_data0;
  logic [CH*LOGQ-1:0]   in_data1;
  logic                 flush;
  logic                 out_valid;
  logic [CH*LOGQ-1:0]   out_data0;
  logic [CH*LOGQ-1:0]   out_data1;
  logic                 busy;
  logic                 err;

  modport master (
    output cfg_load, cfg_log_d, in_valid, in_data0, in_data1, flush,
    input  out_valid, out_data0, out_data1, busy, err
  );

  modport slave (
    input  cfg_load, cfg_log_d, in_valid, in_data0, in_data1, flush,
    output out_valid, out_data0, out_data1, busy, err
  );

endinterface

// File: rtl/ntt_mdc_commutator_rt_delay_line.sv
// -----------------------------------------------------------------------------
// ntt_mdc_commutator_rt_delay_line
// Circular-buffer delay of D = 2^i_log_d advances (D <= 2^LOGD_MAX).
// o_rdata always shows the word written D advances ago at the current slot
// (read-before-write); it is meaningless until D words have been written.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointer only)
//   i_clr      : synchronous pointer clear (new configuration)
//   i_adv      : write i_wdata at the current slot and advance the pointer
//   i_log_d    : runtime log2 of the delay
//   i_wdata    : word entering the line
//   o_rdata    : word leaving the line
// -----------------------------------------------------------------------------
module ntt_mdc_commutator_rt_delay_line
  import ntt_mdc_commutator_rt_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int LOGD_MAX = 7,
  parameter int LOGDW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_adv,
  input  logic [LOGDW-1:0] i_log_d,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 1 << LOGD_MAX;

  logic [LOGD_MAX:0]   w_d;
  logic [LOGD_MAX-1:0] w_mask;
  logic [LOGD_MAX-1:0] r_ptr;
  logic [LOGD_MAX-1:0] w_ptr_nxt;
  logic [LOGD_MAX-1:0] w_addr;
  logic [WIDTH-1:0]    r_mem [DEPTH];

  assign w_d    = (LOGD_MAX+1)'(1) << i_log_d;
  // D-1 truncated to LOGD_MAX bits: all-ones for D = 2^LOGD_MAX, zero for D = 1.
  assign w_mask = LOGD_MAX'(w_d - (LOGD_MAX+1)'(1));

  // The pointer runs freely over the full buffer; masking gives modulo D,
  // which is exact because D divides 2^LOGD_MAX.
  assign w_addr = r_ptr & w_mask;

  always_comb begin
    w_ptr_nxt = r_ptr;
    if (i_clr) begin
      w_ptr_nxt = '0;
    end else if (i_adv) begin
      w_ptr_nxt = r_ptr + LOGD_MAX'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end

  if (LOGD_MAX <= DIST_RAM_MAX_LOGD) begin : g_dist
    // Asynchronous read of the slot about to be overwritten.
    always_ff @(posedge clk) begin
      if (i_adv) begin
        r_mem[w_addr] <= i_wdata;
      end
    end
    assign o_rdata = r_mem[w_addr];
  end else begin : g_bram
    // Registered read: prefetch the slot the pointer will sit on next cycle.
    // When that slot is the one being written (D = 1) forward the write data
    // so the read still returns the word from one advance ago.
    logic [LOGD_MAX-1:0] w_addr_nxt;
    logic [WIDTH-1:0]    r_rdata;

    assign w_addr_nxt = w_ptr_nxt & w_mask;

    always_ff @(posedge clk) begin
      if (i_adv) begin
        r_mem[w_addr] <= i_wdata;
      end
      if (i_adv && (w_addr_nxt == w_addr)) begin
        r_rdata <= i_wdata;
      end else begin
        r_rdata <= r_mem[w_addr_nxt];
      end
    end
    assign o_rdata = r_rdata;
  end

endmodule

// File: rtl/ntt_mdc_commutator_rt.sv
// -----------------------------------------------------------------------------
// ntt_mdc_commutator_rt
// Runtime-configurable delay-switch-delay commutator for radix-2 MDC NTT/INTT
// pipelines. Each beat carries CH word pairs; for beat k (counted since the
// last cfg_load) and D = 2^log_d:
//   u0 = in0[k], u1 = in1[k-D]
//   sel = bit log_d of k; sel ? (s0,s1) = (u1,u0) : (s0,s1) = (u0,u1)
//   out0[k] = s0[k-D], out1[k] = s1[k]
// Outputs are registered and valid only for beats k >= D.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of ntt_mdc_commutator_rt_if
//     cfg_load/cfg_log_d : start a new stream with delay 2^cfg_log_d
//     in_valid/in_data*  : input beats (ignored in IDLE, rejected in DRAIN)
//     flush              : issue D internal zero beats to drain the tail
//     out_valid/out_data*: output beats
//     busy               : FILL, RUN or DRAIN
//     err                : sticky; beat dropped or cfg_log_d clamped
// -----------------------------------------------------------------------------
module ntt_mdc_commutator_rt
  import ntt_mdc_commutator_rt_pkg::*;
#(
  parameter int LOGQ     = LOGQ_DEF,
  parameter int CH       = 1,
  parameter int LOGD_MAX = 7,
  parameter int LOGDW    = $clog2(LOGD_MAX+1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ntt_mdc_commutator_rt_if.slave bus
);

  localparam int W  = CH * LOGQ;
  localparam int CW = LOGD_MAX + 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LOGDW-1:0] r_log_d;
  logic [LOGDW-1:0] w_log_d_cfg;
  logic [CW-1:0]    r_beat;
  logic [CW-1:0]    r_drain;
  logic [CW-1:0]    w_d;
  logic [CW-1:0]    w_d_m1;
  logic             r_filled;
  logic             r_err;

  logic             w_load;
  logic             w_active;
  logic             w_drain_st;
  logic             w_flush_go;
  logic             w_accept;
  logic             w_sel;
  logic             w_last_drain;
  logic             w_cfg_bad;
  logic             w_drop;

  logic [W-1:0]     w_u0;
  logic [W-1:0]     w_in1;
  logic [W-1:0]     w_u1;
  logic [W-1:0]     w_s0;
  logic [W-1:0]     w_s1;
  logic [W-1:0]     w_s0_dly;

  logic             r_out_valid;
  logic [W-1:0]     r_out0;
  logic [W-1:0]     r_out1;

  // ---------------------------------------------------------------------------
  // Beat qualification
  // ---------------------------------------------------------------------------
  assign w_load     = bus.cfg_load;
  assign w_active   = (r_state == ST_FILL) || (r_state == ST_RUN);
  assign w_drain_st = (r_state == ST_DRAIN);

  // cfg_load beats flush, flush beats in_valid.
  assign w_flush_go = !w_load && w_active && bus.flush;
  assign w_accept   = !w_load &&
                      ((w_active && bus.in_valid && !bus.flush) || w_drain_st);
  assign w_drop     = !w_load && bus.in_valid &&
                      (w_drain_st || (w_active && bus.flush));

  assign w_d          = CW'(1) << r_log_d;
  assign w_d_m1       = w_d - CW'(1);
  assign w_sel        = |(r_beat & w_d);
  assign w_last_drain = w_drain_st && (r_drain == w_d_m1);

  assign w_cfg_bad   = int'(bus.cfg_log_d) > LOGD_MAX;
  assign w_log_d_cfg = w_cfg_bad ? LOGDW'(LOGD_MAX) : bus.cfg_log_d;

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (w_load) begin
      w_state_nxt = ST_FILL;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_flush_go) begin
            w_state_nxt = ST_DRAIN;
          end else if (w_accept && (r_beat == w_d_m1)) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_flush_go) begin
            w_state_nxt = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_last_drain) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_log_d  <= '0;
      r_beat   <= '0;
      r_drain  <= '0;
      r_filled <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_load) begin
        r_log_d <= w_log_d_cfg;
      end

      if (w_load) begin
        r_beat <= '0;
      end else if (w_accept) begin
        r_beat <= r_beat + CW'(1);
      end

      if (w_load || w_flush_go) begin
        r_drain <= '0;
      end else if (w_drain_st) begin
        r_drain <= r_drain + CW'(1);
      end

      // r_filled means D beats are already in: the current beat has k >= D.
      // The beat counter wraps, so this flag (not the counter) gates out_valid.
      if (w_load) begin
        r_filled <= 1'b0;
      end else if (w_accept && (r_beat == w_d_m1)) begin
        r_filled <= 1'b1;
      end

      if (w_load) begin
        r_err <= w_cfg_bad;
      end else if (w_drop) begin
        r_err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: delay lane 1, swap on odd D-blocks, delay lane 0
  // ---------------------------------------------------------------------------
  assign w_u0  = w_drain_st ? '0 : bus.in_data0;
  assign w_in1 = w_drain_st ? '0 : bus.in_data1;

  ntt_mdc_commutator_rt_delay_line #(
    .WIDTH    (W),
    .LOGD_MAX (LOGD_MAX),
    .LOGDW    (LOGDW)
  ) u_dly_lane1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_load),
    .i_adv   (w_accept),
    .i_log_d (r_log_d),
    .i_wdata (w_in1),
    .o_rdata (w_u1)
  );

  // The select is common to every channel, so the swap runs on the full bus.
  assign w_s0 = w_sel ? w_u1 : w_u0;
  assign w_s1 = w_sel ? w_u0 : w_u1;

  ntt_mdc_commutator_rt_delay_line #(
    .WIDTH    (W),
    .LOGD_MAX (LOGD_MAX),
    .LOGDW    (LOGDW)
  ) u_dly_lane0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_load),
    .i_adv   (w_accept),
    .i_log_d (r_log_d),
    .i_wdata (w_s0),
    .o_rdata (w_s0_dly)
  );

  // ---------------------------------------------------------------------------
  // Output registers: data only moves on accepted beats, otherwise holds.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out0      <= '0;
      r_out1      <= '0;
    end else begin
      r_out_valid <= w_accept && r_filled;
      if (w_accept) begin
        r_out0 <= w_s0_dly;
        r_out1 <= w_s1;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data0 = r_out0;
  assign bus.out_data1 = r_out1;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.err       = r_err;

endmodule

// File: tb/tb_ntt_mdc_commutator_rt.sv
// Directed bench for ntt_mdc_commutator_rt (CH=4, LOGD_MAX=7, 4-bit cfg_log_d).
// Table rows are one clock each; channel c carries base + 1000*c.
module tb_ntt_mdc_commutator_rt;
  import ntt_mdc_commutator_rt_pkg::*;

  localparam int LOGQ     = 64;
  localparam int CH       = 4;
  localparam int LOGD_MAX = 7;
  localparam int LOGDW    = 4;
  localparam int W        = CH * LOGQ;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ntt_mdc_commutator_rt_if #(.LOGQ(LOGQ), .CH(CH), .LOGDW(LOGDW)) bus ();

  ntt_mdc_commutator_rt #(
    .LOGQ     (LOGQ),
    .CH       (CH),
    .LOGD_MAX (LOGD_MAX),
    .LOGDW    (LOGDW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic             ld;
    logic [LOGDW-1:0] logd;
    logic             vld;
    logic             fl;
    int unsigned      i0;
    int unsigned      i1;
    logic             ev;
    logic             cd;
    int unsigned      e0;
    int unsigned      e1;
    logic             eb;
    logic             ee;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [W-1:0] pack(input int unsigned base);
    logic [W-1:0] v;
    for (int c = 0; c < CH; c++) begin
      v[c*LOGQ +: LOGQ] = LOGQ'(base) + LOGQ'(c * 1000);
    end
    return v;
  endfunction

  task automatic add(input int ld, input int logd, input int vld, input int fl,
                     input int i0, input int i1, input int ev, input int cd,
                     input int e0, input int e1, input int eb, input int ee);
    vec_t v;
    v.ld = (ld != 0); v.logd = LOGDW'(logd); v.vld = (vld != 0); v.fl = (fl != 0);
    v.i0 = i0; v.i1 = i1; v.ev = (ev != 0); v.cd = (cd != 0);
    v.e0 = e0; v.e1 = e1; v.eb = (eb != 0); v.ee = (ee != 0);
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [W-1:0] got,
                     input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s idx=%0d got=%h want=%h", name, idx, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Ramp model, straight from the commutator equations with D = 128.
  function automatic logic [LOGQ-1:0] rin0(input int c, input int k);
    if (k >= 256) return '0;
    return (LOGQ'(c) << 32) | LOGQ'(k);
  endfunction
  function automatic logic [LOGQ-1:0] rin1(input int c, input int k);
    if (k >= 256) return '0;
    return (LOGQ'(c) << 32) | LOGQ'(k) | LOGQ'(32'h8000);
  endfunction
  function automatic int rsel(input int k);
    return (k >> 7) & 1;
  endfunction
  function automatic logic [LOGQ-1:0] rs0(input int c, input int j);
    return (rsel(j) != 0) ? rin1(c, j - 128) : rin0(c, j);
  endfunction

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v0;
    logic [W-1:0] v1;

    bus.cfg_load = 1'b0; bus.cfg_log_d = '0; bus.in_valid = 1'b0;
    bus.in_data0 = '0; bus.in_data1 = '0; bus.flush = 1'b0;

    // ---- D=2 basic: (10,12) (11,13) (20,22) (21,23)
    add(1,1,0,0, 0, 0, 0,0, 0, 0, 1,0);
    add(0,0,1,0,10,20, 0,0, 0, 0, 1,0);
    add(0,0,1,0,11,21, 0,0, 0, 0, 1,0);
    add(0,0,1,0,12,22, 1,0,10,12, 1,0);
    add(0,0,1,0,13,23, 1,0,11,13, 1,0);
    add(0,0,0,1, 0, 0, 0,1,11,13, 1,0);
    add(0,0,0,0, 0, 0, 1,0,20,22, 1,0);
    add(0,0,0,0, 0, 0, 1,0,21,23, 0,0);
    add(0,0,1,1,55,55, 0,1,21,23, 0,0);   // IDLE ignores valid and flush
    // ---- D=1: (1,3) (2,4)
    add(1,0,0,0, 0, 0, 0,0, 0, 0, 1,0);
    add(0,0,1,0, 1, 2, 0,0, 0, 0, 1,0);
    add(0,0,1,0, 3, 4, 1,0, 1, 3, 1,0);
    add(0,0,0,1, 0, 0, 0,1, 1, 3, 1,0);
    add(0,0,0,0, 0, 0, 1,0, 2, 4, 0,0);
    add(0,0,0,0, 0, 0, 0,1, 2, 4, 0,0);
    // ---- D=2 with input gaps: same pairs, data held in gaps
    add(1,1,0,0, 0, 0, 0,0, 0, 0, 1,0);
    add(0,0,1,0,10,20, 0,0, 0, 0, 1,0);
    add(0,0,0,0, 0, 0, 0,0, 0, 0, 1,0);
    add(0,0,1,0,11,21, 0,0, 0, 0, 1,0);
    add(0,0,0,0, 0, 0, 0,0, 0, 0, 1,0);
    add(0,0,0,0, 0, 0, 0,0, 0, 0, 1,0);
    add(0,0,0,0, 0, 0, 0,0, 0, 0, 1,0);
    add(0,0,1,0,12,22, 1,0,10,12, 1,0);
    add(0,0,0,0, 0, 0, 0,1,10,12, 1,0);
    add(0,0,0,0, 0, 0, 0,1,10,12, 1,0);
    add(0,0,1,0,13,23, 1,0,11,13, 1,0);
    add(0,0,0,1, 0, 0, 0,1,11,13, 1,0);
    add(0,0,0,0, 0, 0, 1,0,20,22, 1,0);
    add(0,0,0,0, 0, 0, 1,0,21,23, 0,0);
    // ---- in_valid during DRAIN: err set, drain output intact
    add(1,1,0,0, 0, 0, 0,0, 0, 0, 1,0);
    add(0,0,1,0,10,20, 0,0, 0, 0, 1,0);
    add(0,0,1,0,11,21, 0,0, 0, 0, 1,0);
    add(0,0,1,0,12,22, 1,0,10,12, 1,0);
    add(0,0,1,0,13,23, 1,0,11,13, 1,0);
    add(0,0,0,1, 0, 0, 0,1,11,13, 1,0);
    add(0,0,1,0,99,99, 1,0,20,22, 1,1);
    add(0,0,1,0,99,99, 1,0,21,23, 0,1);
    add(0,0,0,0, 0, 0, 0,1,21,23, 0,1);
    // ---- D=8 into RUN, then reload with D=2 (drops old data, clears err)
    add(1,3,0,0, 0, 0, 0,0, 0, 0, 1,0);
    for (int i = 0; i < 9; i++) begin
      add(0,0,1,0,100+i,200+i, (i == 8) ? 1 : 0,0,100,108, 1,0);
    end
    add(1,1,1,0,77,77, 0,0, 0, 0, 1,0);
    add(0,0,1,0,10,20, 0,0, 0, 0, 1,0);
    add(0,0,1,0,11,21, 0,0, 0, 0, 1,0);
    add(0,0,1,0,12,22, 1,0,10,12, 1,0);
    add(0,0,1,0,13,23, 1,0,11,13, 1,0);
    add(0,0,0,1, 0, 0, 0,1,11,13, 1,0);
    add(0,0,0,0, 0, 0, 1,0,20,22, 1,0);
    add(0,0,0,0, 0, 0, 1,0,21,23, 0,0);

    // ---- reset state
    step();
    step();
    chk("rst_out_valid", 0, W'(bus.out_valid), W'(0));
    chk("rst_busy",      0, W'(bus.busy),      W'(0));
    chk("rst_err",       0, W'(bus.err),       W'(0));
    chk("rst_out_data0", 0, bus.out_data0,     '0);
    chk("rst_out_data1", 0, bus.out_data1,     '0);
    rst_n = 1'b1;

    // ---- table
    for (int i = 0; i < tbl.size(); i++) begin
      bus.cfg_load  = tbl[i].ld;
      bus.cfg_log_d = tbl[i].logd;
      bus.in_valid  = tbl[i].vld;
      bus.flush     = tbl[i].fl;
      bus.in_data0  = pack(tbl[i].i0);
      bus.in_data1  = pack(tbl[i].i1);
      step();
      chk("out_valid", i, W'(bus.out_valid), W'(tbl[i].ev));
      chk("busy",      i, W'(bus.busy),      W'(tbl[i].eb));
      chk("err",       i, W'(bus.err),       W'(tbl[i].ee));
      if (tbl[i].ev || tbl[i].cd) begin
        chk("out_data0", i, bus.out_data0, pack(tbl[i].e0));
        chk("out_data1", i, bus.out_data1, pack(tbl[i].e1));
      end
    end
    bus.cfg_load = 1'b0; bus.in_valid = 1'b0; bus.flush = 1'b0;

    // ---- cfg_log_d=9 clamps to 7 (D=128), 256-beat ramp then flush
    bus.cfg_load = 1'b1; bus.cfg_log_d = LOGDW'(9);
    step();
    bus.cfg_load = 1'b0;
    chk("clamp_err",  0, W'(bus.err),  W'(1));
    chk("clamp_busy", 0, W'(bus.busy), W'(1));
    for (int k = 0; k < 384; k++) begin
      if (k < 256) begin
        for (int c = 0; c < CH; c++) begin
          v0[c*LOGQ +: LOGQ] = rin0(c, k);
          v1[c*LOGQ +: LOGQ] = rin1(c, k);
        end
        bus.in_data0 = v0; bus.in_data1 = v1; bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0; bus.in_data0 = '0; bus.in_data1 = '0;
      end
      step();
      if (k == 255) begin
        bus.in_valid = 1'b0; bus.flush = 1'b1;
        chk("ramp_last_in_valid", k, W'(bus.out_valid), W'(1));
        step();
        bus.flush = 1'b0;
        chk("ramp_flush_gap", k, W'(bus.out_valid), W'(0));
        continue;
      end
      chk("ramp_out_valid", k, W'(bus.out_valid), W'(k >= 128));
      if (k >= 128) begin
        for (int c = 0; c < CH; c++) begin
          chk("ramp_out0", k, W'(ch_word(512'(bus.out_data0), c)), W'(rs0(c, k - 128)));
          chk("ramp_out1", k, W'(ch_word(512'(bus.out_data1), c)),
              W'((rsel(k) != 0) ? rin0(c, k) : rin1(c, k - 128)));
        end
      end
      if (k >= 256) begin
        chk("ramp_busy", k, W'(bus.busy), W'(k != 383));
      end
    end
    chk("ramp_err_sticky", 0, W'(bus.err), W'(1));

    // ---- asynchronous reset in RUN
    bus.cfg_load = 1'b1; bus.cfg_log_d = LOGDW'(1);
    step();
    bus.cfg_load = 1'b0; bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.in_data0 = pack(10 + k); bus.in_data1 = pack(20 + k);
      step();
    end
    chk("pre_rst_valid", 0, W'(bus.out_valid), W'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 0, W'(bus.out_valid), W'(0));
    chk("async_rst_busy",  0, W'(bus.busy),      W'(0));
    chk("async_rst_data0", 0, bus.out_data0,     '0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_idle_busy",  0, W'(bus.busy),      W'(0));
    chk("post_rst_idle_valid", 0, W'(bus.out_valid), W'(0));
    bus.in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
